// File: rtl/pipe_addsub_pkg.sv
// Shared constants, stage-count helper and stage payload type for pipe_addsub_32.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_addsub_pkg;

  // Result bits resolved by each pipeline stage.
  localparam int SLICE_W = 8;

  // Widest operand the payload struct can carry; bits above WIDTH stay zero.
  localparam int MAX_W = 128;

  function automatic int stage_count(input int width);
    return width / SLICE_W;
  endfunction

  // One beat travelling down the skewed pipeline: resolved result bytes
  // accumulate in res while the operand bytes still to be resolved ride along.
  typedef struct packed {
    logic             vld;
    logic             sub;
    logic             carry;      // carry out of the last resolved byte
    logic             cmp_carry;  // carry of the internal a - b compare chain
    logic             eq;         // all resolved bytes of a and b identical
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/addsub_slice_8.sv
// 8-bit carry-lookahead adder slice with carry-in, carry-out and signed overflow.
// Latency: combinational.
// Backpressure: none (pure logic).
module addsub_slice_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,    // already inverted by the caller for subtract
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co,
  output logic       ovf   // signed overflow if this is the top slice
);

  logic [7:0] g0, g1, g2, g3;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] c_out;

  // Parallel-prefix group generate/propagate over 1, 2 and 4 bit spans.
  assign g0 = a & b;
  assign p0 = a ^ b;
  assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
  assign p1 = p0 & {p0[6:0], 1'b1};
  assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
  assign p2 = p1 & {p1[5:0], 2'b11};
  assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});
  assign p3 = p2 & {p2[3:0], 4'b1111};

  // c_out[i] is the carry out of bit i, folded with the slice carry-in.
  assign c_out = g3 | (p3 & {8{ci}});
  assign sum   = p0 ^ {c_out[6:0], ci};
  assign co    = c_out[7];
  assign ovf   = (a[7] == b[7]) & (sum[7] != a[7]);

endmodule

// File: rtl/pipe_addsub_32.sv
// Skewed-pipeline add/subtract, one byte per stage; optional compare flags via PIPE_ADDSUB_CMP_FLAGS_EN.
// Latency: WIDTH/8 cycles from input transfer to o_valid, one beat per cycle.
// Backpressure: o_ready = ~o_valid | i_ready; the whole pipeline freezes while the output is stalled.
module pipe_addsub_32 #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_lt,
  output logic             o_eq
);
  import pipe_addsub_pkg::*;

  localparam int N = stage_count(WIDTH);
  localparam int TOP = (N - 1) * SLICE_W;

  stage_t src;
  stage_t stage_q [N-1];
  stage_t stage_d [N-1];
  logic   advance;

  logic             out_vld;
  logic [WIDTH-1:0] out_res;
  logic             out_carry;
  logic             out_ovf;
  logic [WIDTH-1:0] last_res;
  logic             last_carry;
  logic             last_ovf;

  assign advance = ~out_vld | i_ready;

  // Build the incoming beat; subtract enters as a + ~b with carry-in 1.
  always_comb begin
    src       = '0;
    src.vld   = i_valid;
    src.sub   = i_sub;
    src.carry = i_sub;
`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
    src.cmp_carry = 1'b1;
    src.eq        = 1'b1;
`endif
    src.a[WIDTH-1:0] = i_data_a;
    src.b[WIDTH-1:0] = i_data_b;
  end

  for (genvar k = 0; k < N - 1; k++) begin : g_stage
    stage_t             prev;
    stage_t             nxt;
    logic [SLICE_W-1:0] a_byte, b_byte, b_eff, sum;
    logic               cout, ovf;

    if (k == 0) begin : g_first
      assign prev = src;
    end else begin : g_next
      assign prev = stage_q[k-1];
    end

    assign a_byte = prev.a[k*SLICE_W +: SLICE_W];
    assign b_byte = prev.b[k*SLICE_W +: SLICE_W];
    assign b_eff  = prev.sub ? ~b_byte : b_byte;

    addsub_slice_8 u_slice (
      .a   (a_byte),
      .b   (b_eff),
      .ci  (prev.carry),
      .sum (sum),
      .co  (cout),
      .ovf (ovf)
    );

`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
    logic [SLICE_W:0] cmp_sum;
    assign cmp_sum = {1'b0, a_byte} + {1'b0, ~b_byte} + {{SLICE_W{1'b0}}, prev.cmp_carry};
`endif

    // Resolve byte k and hand the beat to the next stage.
    always_comb begin
      nxt                              = prev;
      nxt.res[k*SLICE_W +: SLICE_W]    = sum;
      nxt.carry                        = cout;
`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
      nxt.cmp_carry = cmp_sum[SLICE_W];
      nxt.eq        = prev.eq & (a_byte == b_byte);
`endif
      // Overflow only matters at the top byte, which the last stage computes.
      if (ovf) nxt.res[k*SLICE_W +: SLICE_W] = sum;
    end

    assign stage_d[k] = nxt;
  end

  // Last stage resolves the top byte straight into the output registers.
  logic [SLICE_W-1:0] top_a, top_b, top_b_eff, top_sum;

  assign top_a     = stage_q[N-2].a[TOP +: SLICE_W];
  assign top_b     = stage_q[N-2].b[TOP +: SLICE_W];
  assign top_b_eff = stage_q[N-2].sub ? ~top_b : top_b;

  addsub_slice_8 u_slice_top (
    .a   (top_a),
    .b   (top_b_eff),
    .ci  (stage_q[N-2].carry),
    .sum (top_sum),
    .co  (last_carry),
    .ovf (last_ovf)
  );

  assign last_res = {top_sum, stage_q[N-2].res[TOP-1:0]};

`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
  logic [SLICE_W-1:0] diff_top;
  logic               diff_ovf;
  logic               last_lt, last_eq, out_lt, out_eq;

  // Top byte of the internal a - b; signed a < b is msb xor overflow.
  assign diff_top = top_a + ~top_b + {{(SLICE_W-1){1'b0}}, stage_q[N-2].cmp_carry};
  assign diff_ovf = (top_a[SLICE_W-1] != top_b[SLICE_W-1]) & (diff_top[SLICE_W-1] != top_a[SLICE_W-1]);
  assign last_lt  = diff_top[SLICE_W-1] ^ diff_ovf;
  assign last_eq  = stage_q[N-2].eq & (top_a == top_b);

  // Flag registers share the output stage enable so they stay aligned with o_valid.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      out_lt <= last_lt;
      out_eq <= last_eq;
    end
  end

  assign o_lt = out_vld & out_lt;
  assign o_eq = out_vld & out_eq;
`else
  assign o_lt = 1'b0;
  assign o_eq = 1'b0;
`endif

  // Whole pipeline advances together; reset only clears the valid bits.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      for (int k = 0; k < N - 1; k++) begin
        stage_q[k] <= stage_d[k];
      end
      out_vld   <= stage_q[N-2].vld;
      out_res   <= last_res;
      out_carry <= last_carry;
      out_ovf   <= last_ovf;
    end
    if (i_rst) begin
      for (int k = 0; k < N - 1; k++) begin
        stage_q[k].vld <= 1'b0;
      end
      out_vld <= 1'b0;
    end
  end

  // Data registers are not reset, so outputs are forced to zero when idle.
  assign o_valid    = out_vld;
  assign o_ready    = advance;
  assign o_result   = out_vld ? out_res : '0;
  assign o_carry    = out_vld & out_carry;
  assign o_overflow = out_vld & out_ovf;

endmodule

// File: tb/tb_pipe_addsub_32.sv
// Scoreboard bench for pipe_addsub_32: random and directed beats against an arithmetic model.
// Latency: checks N-cycle latency and full-rate throughput.
// Backpressure: exercises output stalls, mid-flight reset and idle-output zeroing.
module tb_pipe_addsub_32;

  localparam int W = 32;
  localparam int N = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_rst, i_valid, o_ready, i_sub, o_valid, i_ready;
  logic         o_carry, o_overflow, o_lt, o_eq;
  logic [W-1:0] i_data_a, i_data_b, o_result;

  pipe_addsub_32 #(.WIDTH(W), .SLICE_W(8)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sub      (i_sub),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_lt       (o_lt),
    .o_eq       (o_eq)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         lt;
    logic         eq;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   out_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    exp_t            e;
    longint          sa, sb, t;
    longint unsigned ua, ub;
    sa    = longint'($signed(ta));
    sb    = longint'($signed(tb));
    ua    = {32'd0, ta};
    ub    = {32'd0, tb};
    t     = ts ? sa - sb : sa + sb;
    e.res = ts ? ta - tb : ta + tb;
    e.c   = ts ? (ua >= ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    e.v   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
    e.lt  = (sa < sb);
    e.eq  = (ta == tb);
`else
    e.lt  = 1'b0;
    e.eq  = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Stimulus side of the scoreboard: record every accepted beat.
  always @(negedge clk) begin
    if (i_rst) exp_q.delete();
    else if (i_valid && o_ready) exp_q.push_back(model(i_data_a, i_data_b, i_sub));
  end

  // Monitor: pop on every output transfer, check stall stability and idle zeros.
  logic         held;
  logic [W-1:0] h_res;
  logic         h_c, h_v, h_lt, h_eq;
  initial held = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!i_rst) begin
      if (held)
        check("stall_hold", 64'({o_valid, o_carry, o_overflow, o_lt, o_eq, o_result}),
              64'({1'b1, h_c, h_v, h_lt, h_eq, h_res}));
      if (!o_valid)
        check("idle_zero", 64'({o_result, o_carry, o_overflow, o_lt, o_eq}), 64'd0);
      if (o_valid && !i_ready) begin
        check("stall_ready", 64'(o_ready), 64'd0);
        held = 1'b1;
        h_res = o_result; h_c = o_carry; h_v = o_overflow; h_lt = o_lt; h_eq = o_eq;
      end else begin
        held = 1'b0;
      end
      if (o_valid && i_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", o_result);
        end else begin
          e = exp_q.pop_front();
          check("result",   64'(o_result),   64'(e.res));
          check("carry",    64'(o_carry),    64'(e.c));
          check("overflow", 64'(o_overflow), 64'(e.v));
          check("lt",       64'(o_lt),       64'(e.lt));
          check("eq",       64'(o_eq),       64'(e.eq));
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // One beat into an empty pipeline, checked against fixed expectations and latency.
  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic [W-1:0] er, input logic ec,
                          input logic ev, input logic elt, input logic eeq);
    int lat;
    i_data_a = ta; i_data_b = tb; i_sub = ts; i_valid = 1'b1; i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
    check({nm, "_latency"},  64'(lat),        64'(N));
    check({nm, "_result"},   64'(o_result),   64'(er));
    check({nm, "_carry"},    64'(o_carry),    64'(ec));
    check({nm, "_overflow"}, 64'(o_overflow), 64'(ev));
`ifdef PIPE_ADDSUB_CMP_FLAGS_EN
    check({nm, "_lt"}, 64'(o_lt), 64'(elt));
    check({nm, "_eq"}, 64'(o_eq), 64'(eeq));
`else
    check({nm, "_lt"}, 64'(o_lt), 64'd0);
    check({nm, "_eq"}, 64'(o_eq), 64'd0);
    if (elt || eeq) begin end
`endif
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sent, cyc, base;
    logic xfer;

    i_rst = 1'b1; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b1;
    i_data_a = '0; i_data_b = '0;
    repeat (3) step();
    i_rst = 1'b0;
    step();

    check("rst_valid",    64'(o_valid),    64'd0);
    check("rst_result",   64'(o_result),   64'd0);
    check("rst_carry",    64'(o_carry),    64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_lt",       64'(o_lt),       64'd0);
    check("rst_eq",       64'(o_eq),       64'd0);
    check("rst_ready",    64'(o_ready),    64'd1);

    directed("add_cross", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    directed("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("directed_drain");

    // Backpressure: eight beats streamed, output stalled for cycles 5-7.
    sent = 0; cyc = 0;
    i_valid = 1'b1; i_data_a = rand_word(); i_data_b = rand_word(); i_sub = 1'($urandom_range(0, 1));
    while (sent < 8 && cyc < 50) begin
      i_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      xfer = o_ready;
      if (cyc >= 5 && cyc <= 7) check("bp_ready_low", 64'(o_ready), 64'd0);
      step();
      cyc++;
      if (xfer) begin
        sent++;
        i_data_a = rand_word(); i_data_b = rand_word(); i_sub = 1'($urandom_range(0, 1));
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    check("bp_sent", 64'(sent), 64'd8);
    drain("bp_drain");

    // Reset with three beats in flight plus one presented during reset.
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_data_a = rand_word(); i_data_b = rand_word(); i_sub = 1'($urandom_range(0, 1));
      step();
    end
    i_rst = 1'b1; i_data_a = rand_word(); i_data_b = rand_word();
    step();
    i_rst = 1'b0; i_valid = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      check("rst_flush_valid", 64'(o_valid), 64'd0);
      step();
    end
    directed("post_rst", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("rst_drain");

    // Full rate: 100 back-to-back random beats, must produce 100 results in 100 cycles.
    base = out_count;
    for (int i = 0; i < 100; i++) begin
      i_valid = 1'b1; i_ready = 1'b1;
      i_data_a = rand_word(); i_data_b = rand_word(); i_sub = 1'($urandom_range(0, 1));
      step();
    end
    i_valid = 1'b0;
    repeat (N) step();
    check("fullrate_count", 64'(out_count - base), 64'd100);
    drain("fullrate_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
